mnacidpro_sequencer: RTL and testbench

- Protocol sequencer for the nucleic-acid purification chip's control pads.
- Drives the 11 valve control lines and the 3-valve peristaltic pump through a fixed five-phase protocol: bead load, lysis, bind loop, wash, elute.
- Sits between the host command interface and the chip's control inputs.
- Flush lines are out of scope.

---
 rtl/mnacidpro_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_mnacidpro_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnacidpro_sequencer.sv
// Protocol sequencer for the nucleic-acid purification chip: walks the valve bank and
// the 3-valve peristaltic pump through bead load, lysis, bind, wash and elute.
module mnacidpro_sequencer #(
    parameter int unsigned PUMP_DIV      = 4,
    parameter int unsigned SETTLE_CYC    = 8,
    parameter int unsigned BEAD_STROKES  = 4,
    parameter int unsigned LYSIS_STROKES = 8,
    parameter int unsigned BIND_STROKES  = 16,
    parameter int unsigned WASH_STROKES  = 4,
    parameter int unsigned ELUTE_STROKES = 2,
    parameter int unsigned CW            = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        hold,
    output logic [10:0] valve_ctrl,
    output logic [2:0]  pump,
    output logic [2:0]  phase,
    output logic        busy,
    output logic        done
);

    localparam longint unsigned CNT_LIMIT = 64'd1 << CW;

    if (CW < 1 || CW > 32 ||
        PUMP_DIV < 1 || SETTLE_CYC < 1 ||
        BEAD_STROKES < 1 || LYSIS_STROKES < 1 || BIND_STROKES < 1 ||
        WASH_STROKES < 1 || ELUTE_STROKES < 1 ||
        64'(PUMP_DIV) > CNT_LIMIT || 64'(SETTLE_CYC) > CNT_LIMIT ||
        64'(BEAD_STROKES) > CNT_LIMIT || 64'(LYSIS_STROKES) > CNT_LIMIT ||
        64'(BIND_STROKES) > CNT_LIMIT || 64'(WASH_STROKES) > CNT_LIMIT ||
        64'(ELUTE_STROKES) > CNT_LIMIT) begin : g_bad_param
        $error("mnacidpro_sequencer: counts must be >= 1 and fit in CW bits");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BEAD   = 3'd1,
        S_LYSIS  = 3'd2,
        S_BIND   = 3'd3,
        S_WASH   = 3'd4,
        S_ELUTE  = 3'd5,
        S_SETTLE = 3'd6
    } state_t;

    localparam logic [10:0] ALL_CLOSED = 11'h7FF;
    localparam logic [2:0]  PUMP_STOP  = 3'b111;

    state_t          r_state;
    state_t          r_next;
    logic [CW-1:0]   r_step_cnt;
    logic [CW-1:0]   r_stroke_cnt;
    logic [CW-1:0]   r_settle_cnt;
    logic [2:0]      r_step_idx;
    logic [10:0]     r_valve;
    logic [2:0]      r_pump;
    logic            r_busy;
    logic            r_done;

    logic            w_kill;
    logic            w_run;
    logic            w_step_last;
    logic            w_idx_last;
    logic            w_stroke_last;
    logic            w_settle_last;

    function automatic logic [10:0] f_mask(input state_t s);
        case (s)
            S_BEAD:  return 11'h52F;
            S_LYSIS: return 11'h6D6;
            S_BIND:  return 11'h4CF;
            S_WASH:  return 11'h5BD;
            S_ELUTE: return 11'h1FB;
            default: return ALL_CLOSED;
        endcase
    endfunction

    // Gray-like walk: consecutive steps (including the wrap) differ in one bit.
    function automatic logic [2:0] f_pump(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b110;
            3'd1:    return 3'b100;
            3'd2:    return 3'b101;
            3'd3:    return 3'b001;
            3'd4:    return 3'b011;
            3'd5:    return 3'b010;
            default: return PUMP_STOP;
        endcase
    endfunction

    function automatic logic [CW-1:0] f_last_stroke(input state_t s);
        case (s)
            S_BEAD:  return CW'(BEAD_STROKES - 1);
            S_LYSIS: return CW'(LYSIS_STROKES - 1);
            S_BIND:  return CW'(BIND_STROKES - 1);
            S_WASH:  return CW'(WASH_STROKES - 1);
            S_ELUTE: return CW'(ELUTE_STROKES - 1);
            default: return '0;
        endcase
    endfunction

    function automatic state_t f_succ(input state_t s);
        case (s)
            S_BEAD:  return S_LYSIS;
            S_LYSIS: return S_BIND;
            S_BIND:  return S_WASH;
            S_WASH:  return S_ELUTE;
            default: return S_IDLE;
        endcase
    endfunction

    assign w_kill        = rst || (abort && r_state != S_IDLE);
    assign w_run         = !(hold && r_state != S_IDLE);
    assign w_step_last   = r_step_cnt == CW'(PUMP_DIV - 1);
    assign w_idx_last    = r_step_idx == 3'd5;
    assign w_stroke_last = r_stroke_cnt == f_last_stroke(r_state);
    assign w_settle_last = r_settle_cnt == CW'(SETTLE_CYC - 1);

    // NOTE: every register here is updated with <= so all of them see the pre-edge
    // values of each other; mixing in = would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_state      <= S_IDLE;
            r_next       <= S_BEAD;
            r_step_cnt   <= '0;
            r_stroke_cnt <= '0;
            r_settle_cnt <= '0;
            r_step_idx   <= '0;
            r_valve      <= ALL_CLOSED;
            r_pump       <= PUMP_STOP;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_run) begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_state      <= S_SETTLE;
                        r_next       <= S_BEAD;
                        r_settle_cnt <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (w_settle_last) begin
                        r_settle_cnt <= '0;
                        if (r_next == S_IDLE) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= r_next;
                            r_valve      <= f_mask(r_next);
                            r_pump       <= f_pump(3'd0);
                            r_step_cnt   <= '0;
                            r_step_idx   <= '0;
                            r_stroke_cnt <= '0;
                        end
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_BEAD, S_LYSIS, S_BIND, S_WASH, S_ELUTE: begin
                    if (!w_step_last) begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                    end else begin
                        r_step_cnt <= '0;
                        if (!w_idx_last) begin
                            r_step_idx <= r_step_idx + 3'd1;
                            r_pump     <= f_pump(r_step_idx + 3'd1);
                        end else if (!w_stroke_last) begin
                            r_step_idx   <= '0;
                            r_stroke_cnt <= r_stroke_cnt + 1'b1;
                            r_pump       <= f_pump(3'd0);
                        end else begin
                            r_step_idx   <= '0;
                            r_stroke_cnt <= '0;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                            r_next       <= f_succ(r_state);
                            r_valve      <= ALL_CLOSED;
                            r_pump       <= PUMP_STOP;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valve <= ALL_CLOSED;
                    r_pump  <= PUMP_STOP;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign valve_ctrl = r_valve;
    assign pump       = r_pump;
    assign phase      = r_state;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// Self-checking bench: a per-cycle expected trace is built from the protocol's phase
// list and stroke arithmetic, then walked alongside the DUT with hold/abort/rst events.
module tb_mnacidpro_sequencer;

    localparam int unsigned PUMP_DIV      = 4;
    localparam int unsigned SETTLE_CYC    = 8;
    localparam int unsigned BEAD_STROKES  = 4;
    localparam int unsigned LYSIS_STROKES = 8;
    localparam int unsigned BIND_STROKES  = 16;
    localparam int unsigned WASH_STROKES  = 4;
    localparam int unsigned ELUTE_STROKES = 2;

    // Output-index offsets (0 = first cycle after the start edge) of phases of interest.
    localparam int LYSIS_AT = 112;
    localparam int BIND_AT  = 312;
    localparam int WASH_AT  = 704;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        hold;
    logic [10:0] valve_ctrl;
    logic [2:0]  pump;
    logic [2:0]  phase;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0]  ph;
        logic [10:0] valve;
        logic [2:0]  pmp;
        logic        bsy;
        logic        dn;
    } exp_t;

    exp_t trace[$];

    mnacidpro_sequencer #(
        .PUMP_DIV      (PUMP_DIV),
        .SETTLE_CYC    (SETTLE_CYC),
        .BEAD_STROKES  (BEAD_STROKES),
        .LYSIS_STROKES (LYSIS_STROKES),
        .BIND_STROKES  (BIND_STROKES),
        .WASH_STROKES  (WASH_STROKES),
        .ELUTE_STROKES (ELUTE_STROKES),
        .CW            (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .hold       (hold),
        .valve_ctrl (valve_ctrl),
        .pump       (pump),
        .phase      (phase),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] ph, input logic [10:0] v,
                                input logic [2:0] p, input logic b, input logic d);
        exp_t e;
        e.ph    = ph;
        e.valve = v;
        e.pmp   = p;
        e.bsy   = b;
        e.dn    = d;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        return mk(3'd0, 11'h7FF, 3'b111, 1'b0, 1'b0);
    endfunction

    function automatic int strokes_of(input int ph);
        case (ph)
            1:       return BEAD_STROKES;
            2:       return LYSIS_STROKES;
            3:       return BIND_STROKES;
            4:       return WASH_STROKES;
            default: return ELUTE_STROKES;
        endcase
    endfunction

    function automatic logic [10:0] mask_of(input int ph);
        case (ph)
            1:       return 11'h52F;
            2:       return 11'h6D6;
            3:       return 11'h4CF;
            4:       return 11'h5BD;
            default: return 11'h1FB;
        endcase
    endfunction

    task automatic build_trace();
        logic [2:0] pat [6];
        pat = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
        trace.delete();
        for (int ph = 1; ph <= 5; ph++) begin
            for (int n = 0; n < int'(SETTLE_CYC); n++)
                trace.push_back(mk(3'd6, 11'h7FF, 3'b111, 1'b1, 1'b0));
            for (int j = 0; j < strokes_of(ph) * 6 * int'(PUMP_DIV); j++)
                trace.push_back(mk(3'(ph), mask_of(ph), pat[(j / int'(PUMP_DIV)) % 6], 1'b1, 1'b0));
        end
        for (int n = 0; n < int'(SETTLE_CYC); n++)
            trace.push_back(mk(3'd6, 11'h7FF, 3'b111, 1'b1, 1'b0));
        trace.push_back(mk(3'd0, 11'h7FF, 3'b111, 1'b0, 1'b1));
    endtask

    // Start one protocol run and follow it cycle by cycle. Index -1 disables an event.
    task automatic run_protocol(input string tag, input int hold_at, input int hold_len,
                                input int abort_at, input int rst_at, input bit rand_start,
                                output int done_at);
        exp_t e;
        exp_t obs;
        exp_t prev;
        int   p;
        int   tail;
        bit   ended;
        bit   finished;
        done_at  = -1;
        p        = 0;
        tail     = 0;
        ended    = 1'b0;
        finished = 1'b0;
        prev     = idle_exp();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            e   = ended ? idle_exp() : trace[p];
            obs = mk(phase, valve_ctrl, pump, busy, done);
            n_cmp++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got ph=%0d valve=%h pump=%b busy=%b done=%b, want ph=%0d valve=%h pump=%b busy=%b done=%b",
                         tag, i, obs.ph, obs.valve, obs.pmp, obs.bsy, obs.dn,
                         e.ph, e.valve, e.pmp, e.bsy, e.dn);
            end
            if (i > 0 && obs.ph >= 3'd1 && obs.ph <= 3'd5 && obs.ph == prev.ph) begin
                n_cmp++;
                if ($countones(obs.pmp ^ prev.pmp) > 1) begin
                    n_fail++;
                    $display("FAIL %s pump_step cycle %0d: got %b after %b, want at most one bit change",
                             tag, i, obs.pmp, prev.pmp);
                end
            end
            if (done === 1'b1 && done_at < 0) done_at = i;
            prev = obs;
            if (ended) begin
                if (tail == 3) begin finished = 1'b1; break; end
                tail++;
            end else if (p == trace.size() - 1) begin
                finished = 1'b1;
                break;
            end
            hold  = (hold_at >= 0 && i >= hold_at && i < hold_at + hold_len);
            abort = (i == abort_at);
            rst   = (i == rst_at);
            start = (!ended && rand_start) ? ($urandom_range(0, 7) == 0) : 1'b0;
            @(posedge clk); #1;
            if (rst || abort) ended = 1'b1;
            else if (!ended && !hold) p++;
            rst   = 1'b0;
            abort = 1'b0;
        end
        hold  = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s budget: got run still open after 3000 cycles, want completion", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (mk(phase, valve_ctrl, pump, busy, done) !== idle_exp()) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got ph=%0d valve=%h pump=%b busy=%b done=%b, want idle values",
                         i, phase, valve_ctrl, pump, busy, done);
            end
        end
    endtask

    task automatic test_full_protocol();
        int d;
        run_protocol("full", -1, 0, -1, -1, 1'b0, d);
        n_cmp++;
        if (d !== 864) begin
            n_fail++;
            $display("FAIL full_done_time: got %0d, want 864", d);
        end
    endtask

    task automatic test_hold_bind();
        int d;
        int h;
        h = BIND_AT + int'($urandom_range(0, 300));
        run_protocol("hold_bind", h, 10, -1, -1, 1'b1, d);
        n_cmp++;
        if (d !== 874) begin
            n_fail++;
            $display("FAIL hold_done_time: got %0d, want 874", d);
        end
    endtask

    task automatic test_abort_wash();
        int d;
        run_protocol("abort_wash", -1, 0, WASH_AT + int'($urandom_range(0, 90)), -1, 1'b0, d);
        n_cmp++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL abort_no_done: got done at %0d, want none", d);
        end
        run_protocol("after_abort", -1, 0, -1, -1, 1'b1, d);
        n_cmp++;
        if (d !== 864) begin
            n_fail++;
            $display("FAIL rerun_done_time: got %0d, want 864", d);
        end
    endtask

    task automatic test_rst_lysis();
        int d;
        run_protocol("rst_lysis", -1, 0, -1, LYSIS_AT + int'($urandom_range(0, 180)), 1'b0, d);
        n_cmp++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL rst_no_done: got done at %0d, want none", d);
        end
    endtask

    task automatic test_abort_hold();
        int d;
        int h;
        h = int'($urandom_range(20, 800));
        run_protocol("abort_hold", h, 20, h + 5, -1, 1'b0, d);
        n_cmp++;
        if (d !== -1) begin
            n_fail++;
            $display("FAIL abort_hold_no_done: got done at %0d, want none", d);
        end
    endtask

    task automatic test_idle_events();
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (phase !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_idle: got ph=%0d busy=%b, want ph=0 busy=0", phase, busy);
        end
        hold = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (mk(phase, valve_ctrl, pump, busy, done) !== idle_exp()) begin
            n_fail++;
            $display("FAIL hold_idle: got ph=%0d busy=%b, want idle values", phase, busy);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hold  = 1'b0;
        n_cmp++;
        if (phase !== 3'd6 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_start_idle: got ph=%0d busy=%b, want ph=6 busy=1", phase, busy);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++;
        if (mk(phase, valve_ctrl, pump, busy, done) !== idle_exp()) begin
            n_fail++;
            $display("FAIL abort_settle: got ph=%0d valve=%h pump=%b busy=%b done=%b, want idle values",
                     phase, valve_ctrl, pump, busy, done);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        build_trace();
        test_reset();
        test_full_protocol();
        test_hold_bind();
        test_abort_wash();
        test_rst_lysis();
        test_abort_hold();
        test_idle_events();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
